// File: rtl/trdb_branch_map.sv
// trdb_branch_map: accumulates retired conditional-branch outcomes into an E-Trace branch map
// Ports: clk_i/rst_ni clock and async active-low reset; valid_i/branch_taken_i retired branch
//        and its outcome; flush_i map consumed by the packet emitter; map_o/branches_o
//        accumulated map (1 = not taken) and valid-bit count; is_full_o/is_empty_o count
//        decode; overflow_o sticky flag for a branch dropped while full.
module trdb_branch_map #(
    parameter int unsigned MAP_LEN = 31,
    parameter int unsigned CNT_LEN = 5
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               valid_i,
    input  logic               branch_taken_i,
    input  logic               flush_i,
    output logic [MAP_LEN-1:0] map_o,
    output logic [CNT_LEN-1:0] branches_o,
    output logic               is_full_o,
    output logic               is_empty_o,
    output logic               overflow_o
);
    typedef enum logic [1:0] {EMPTY, FILLING, FULL} state_e;
    state_e             state;
    logic [MAP_LEN-1:0] bit_nx;
    always_comb state = branches_o == '0 ? EMPTY : branches_o == CNT_LEN'(MAP_LEN) ? FULL : FILLING;
    assign is_full_o  = state == FULL;
    assign is_empty_o = state == EMPTY;
    // new outcome placed at the first free slot, so bits above the count stay zero
    assign bit_nx = MAP_LEN'(!branch_taken_i) << branches_o;
    // a branch arriving with a flush starts the next map instead of being lost
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            map_o      <= '0;
            branches_o <= '0;
            overflow_o <= 1'b0;
        end else if (flush_i) begin
            map_o      <= MAP_LEN'(valid_i & !branch_taken_i);
            branches_o <= CNT_LEN'(valid_i);
            overflow_o <= 1'b0;
        end else if (valid_i && state == FULL) begin
            overflow_o <= 1'b1;
        end else if (valid_i) begin
            map_o      <= map_o | bit_nx;
            branches_o <= branches_o + CNT_LEN'(1);
        end
    end
endmodule

// File: tb/tb_trdb_branch_map.sv
// tb_trdb_branch_map: directed self-checking bench for trdb_branch_map
module tb_trdb_branch_map;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        valid_i = 1'b0;
    logic        branch_taken_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [30:0] map_o;
    logic [4:0]  branches_o;
    logic        is_full_o, is_empty_o, overflow_o;
    int          checks = 0;
    int          failures = 0;

    trdb_branch_map dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .branch_taken_i(branch_taken_i),
        .flush_i(flush_i), .map_o(map_o), .branches_o(branches_o), .is_full_o(is_full_o),
        .is_empty_o(is_empty_o), .overflow_o(overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s differs: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic v, input logic t, input logic f);
        valid_i = v;
        branch_taken_i = t;
        flush_i = f;
        @(negedge clk_i);
    endtask

    task automatic state(input string tag, input logic [30:0] m, input logic [4:0] n,
                         input logic full, input logic empty, input logic ovf);
        chk({tag, "_map"}, 64'(map_o), 64'(m));
        chk({tag, "_cnt"}, 64'(branches_o), 64'(n));
        chk({tag, "_full"}, 64'(is_full_o), 64'(full));
        chk({tag, "_empty"}, 64'(is_empty_o), 64'(empty));
        chk({tag, "_ovf"}, 64'(overflow_o), 64'(ovf));
    endtask

    initial begin
        #12;
        state("reset", 31'h0, 5'd0, 1'b0, 1'b1, 1'b0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick(1, 1, 0);
        state("lat1", 31'h0, 5'd1, 1'b0, 1'b0, 1'b0);
        tick(1, 0, 0);
        tick(1, 1, 0);
        valid_i = 1'b0;
        state("tnt", 31'h2, 5'd3, 1'b0, 1'b0, 1'b0);
        tick(1, 0, 0);
        tick(1, 1, 0);
        state("five", 31'hA, 5'd5, 1'b0, 1'b0, 1'b0);
        tick(0, 0, 1);
        state("flush", 31'h0, 5'd0, 1'b0, 1'b1, 1'b0);
        tick(1, 0, 0);
        for (int i = 0; i < 10; i++) tick(0, 1'(i), 0);
        state("idle", 31'h1, 5'd1, 1'b0, 1'b0, 1'b0);
        tick(0, 0, 1);
        for (int i = 0; i < 30; i++) tick(1, 0, 0);
        state("thirty", 31'h3FFFFFFF, 5'd30, 1'b0, 1'b0, 1'b0);
        tick(1, 0, 0);
        state("full", 31'h7FFFFFFF, 5'd31, 1'b1, 1'b0, 1'b0);
        tick(1, 1, 0);
        state("drop", 31'h7FFFFFFF, 5'd31, 1'b1, 1'b0, 1'b1);
        tick(0, 0, 0);
        chk("ovf_sticky", 64'(overflow_o), 64'd1);
        tick(1, 0, 1);
        state("flush_val", 31'h1, 5'd1, 1'b0, 1'b0, 1'b0);
        tick(1, 1, 1);
        state("flush_tkn", 31'h0, 5'd1, 1'b0, 1'b0, 1'b0);
        tick(0, 0, 1);
        tick(0, 0, 1);
        state("flush_empty", 31'h0, 5'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) tick(1, 0, 0);
        valid_i = 1'b0;
        state("ten", 31'h3FF, 5'd10, 1'b0, 1'b0, 1'b0);
        #2 rst_ni = 1'b0;
        #1 state("async_rst", 31'h0, 5'd0, 1'b0, 1'b1, 1'b0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        state("post_rst", 31'h0, 5'd0, 1'b0, 1'b1, 1'b0);
        tick(1, 1, 0);
        tick(1, 0, 0);
        state("restart", 31'h2, 5'd2, 1'b0, 1'b0, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/trdb_branch_map.md
TRDB_BRANCH_MAP -- requirements
Module: trdb_branch_map

Interface
REQ-001 SHALL have parameter MAP_LEN, default 31 (trdb_pkg BRANCH_MAP_LEN), the number of branch outcome bits held.
REQ-002 SHALL have parameter CNT_LEN, default 5 (trdb_pkg BRANCH_COUNT_LEN), the branch counter width.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port valid_i, input, 1, one conditional branch retired this cycle.
REQ-006 SHALL have port branch_taken_i, input, 1, outcome of that branch (1 = taken); ignored when valid_i=0.
REQ-007 SHALL have port flush_i, input, 1, the packet emitter consumed the current map this cycle.
REQ-008 SHALL have port map_o, output, MAP_LEN, accumulated outcomes; bit i = branch i; 1 = NOT taken, per E-Trace encoding.
REQ-009 SHALL have port branches_o, output, CNT_LEN, number of valid bits in map_o (0..MAP_LEN).
REQ-010 SHALL have port is_full_o, output, 1, high when branches_o == MAP_LEN.
REQ-011 SHALL have port is_empty_o, output, 1, high when branches_o == 0.
REQ-012 SHALL have port overflow_o, output, 1, sticky flag: a branch arrived while full and was dropped.

Function
REQ-013 SHALL hold map and count in registers; map_o, branches_o, overflow_o are direct register outputs, is_full_o/is_empty_o decoded combinationally from the count register.
REQ-014 SHALL, on valid_i=1, flush_i=0, not full: write ~branch_taken_i into map bit [count], increment count by 1; visible on outputs the next cycle (latency 1).
REQ-015 SHALL leave map bits at index >= count at 0 at all times.
REQ-016 SHALL, on flush_i=1, valid_i=0: clear map to 0, count to 0, overflow to 0 next cycle.
REQ-017 SHALL, on flush_i=1 and valid_i=1 same cycle: clear map, then store the new outcome at bit 0 with count=1 and overflow=0 (new branch belongs to the next map, never lost).
REQ-018 SHALL, on valid_i=1, flush_i=0, full: leave map and count unchanged and set overflow to 1.
REQ-019 SHALL hold all state unchanged when valid_i=0 and flush_i=0.
REQ-020 SHALL treat flush_i while empty as a no-op beyond clearing overflow.
REQ-021 SHALL never wrap count: count saturates at MAP_LEN; arithmetic in CNT_LEN bits with MAP_LEN <= 2^CNT_LEN-1.
REQ-022 SHALL implement a 3-state view derived from count: EMPTY (0), FILLING (1..MAP_LEN-1), FULL (MAP_LEN); transitions only via REQ-014/016/017/018.

Reset
REQ-023 SHALL, while rst_ni=0, asynchronously force map_o=0, branches_o=0, overflow_o=0, hence is_empty_o=1, is_full_o=0.
REQ-024 SHALL, on reset assertion mid-accumulation, discard the partial map; first valid_i after deassertion writes bit 0.

Verification
REQ-025 SHALL verify: reset, then 3 branches taken/not/taken on consecutive cycles -> next cycle map_o=31'h2, branches_o=3, is_empty_o=0.
REQ-026 SHALL verify: 31 not-taken branches -> map_o=31'h7FFFFFFF, branches_o=31, is_full_o=1; 32nd branch without flush -> map unchanged, overflow_o=1.
REQ-027 SHALL verify: full map, flush_i=1 with valid_i=1 taken=0 same cycle -> map_o=31'h1, branches_o=1, overflow_o=0, is_full_o=0.
REQ-028 SHALL verify: 5 branches then flush_i alone -> map_o=0, branches_o=0, is_empty_o=1 next cycle.
REQ-029 SHALL verify: rst_ni pulsed low asynchronously (between clock edges) with 10 branches held -> outputs clear immediately, before the next clk_i edge.
REQ-030 SHALL verify: valid_i=0 with branch_taken_i toggling for 10 cycles -> no output change.
